lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//  Load/store initiator between the execute stage and the word-organised data memory.
//  Accepts one RV32I load/store per handshake and issues byte-enabled word accesses.
//  Splits accesses that cross a word boundary into two accesses.
//  Byte/half loads are sign- or zero-extended per funct3, then returned on a response pulse.
// PARAMETERS
//  ADDR_W  10  word-address width of data memory (memory depth = 2**ADDR_W words)
// PORTS
//  clk          in   1       clock, all state updates on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       block can accept a request (high only in IDLE)
//  req_we       in   1       1 = store, 0 = load
//  req_funct3   in   3       RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  req_addr     in   32      byte address
//  req_wdata    in   32      store data (LSBs significant)
//  resp_valid   out  1       one-cycle completion pulse (loads and stores)
//  resp_rdata   out  32      extended load data; 0 for stores and errors
//  resp_err     out  1       illegal funct3, valid with resp_valid
//  mem_en       out  1       memory access strobe
//  mem_we       out  1       write enable, valid with mem_en
//  mem_be       out  4       byte-lane enables, valid with mem_en
//  mem_addr     out  ADDR_W  word address = byte address [ADDR_W+1:2]
//  mem_wdata    out  32      lane-aligned write data
//  mem_rdata    in   32      read data, valid the cycle after a read mem_en
// BEHAVIOUR
//  - Reset (rst_n=0, any time, incl. mid-operation): state IDLE, all outputs 0 except req_ready=1;
//    in-flight access abandoned, no resp_valid.
//  - Handshake: accept when req_valid && req_ready (cycle T); request fields latched at T.
//  - States: IDLE -> ACC0 -> [ACC1] -> WAIT -> RESP -> IDLE; illegal funct3: IDLE -> RESP.
//  - All mem_* and resp_* outputs registered; mem_en high exactly in ACC0 and ACC1.
//  - Illegal: loads 011/110/111, stores any funct3 > 010: no memory access, resp_err=1 at T+1.
//  - o = addr[1:0], sz = 1/2/4 bytes. Split iff o+sz > 4 (h at o=3; w at o!=0).
//  - mem_wdata = rotate-left(req_wdata, 8*o) for both accesses.
//  - ACC0: mem_addr=W, be = (sz-mask << o)[3:0]. ACC1: mem_addr=W+1 mod 2**ADDR_W,
//    be = sz-mask >> (4-o). sz-mask: b=0001, h=0011, w=1111.
//  - Read capture: data of ACC0 sampled in the following cycle (ACC1 or WAIT) as LO;
//    data of ACC1 sampled in WAIT as HI (HI=0 if unsplit).
//  - Load result: x = ({HI,LO} >> 8*o)[31:0]; b: sext x[7:0]; h: sext x[15:0];
//    w: x; bu/hu: zext. Registered into resp_rdata at RESP entry.
//  - Latency (accept T -> resp_valid): aligned 3 cycles (T+3), split 4 (T+4), error 1 (T+1).
//    Stores follow identical timing; resp_rdata=0.
//  - resp_valid high exactly one cycle; resp_rdata/resp_err hold until next response.
//  - req_ready low from T+1 through RESP; request on RESP cycle waits until IDLE.
//  - Address wrap: word 2**ADDR_W-1 + split -> second access to word 0. Upper address bits
//    above ADDR_W+1 ignored.
// TESTING
//  1 sw addr=0x10 wdata=0xDEADBEEF -> T+1 mem_en, we=1, addr=4, be=1111, wdata=0xDEADBEEF; resp T+3.
//  2 lb addr=0x13, mem word4=0x80AABBCC -> be=1000 read, resp_rdata=0xFFFFFF80; lbu -> 0x00000080.
//  3 lh addr=0x0B, word2=0x11AABBCC, word3=0x00000022 -> two reads addr 2 (be 1000), 3 (be 0001);
//    resp_rdata=0x00002211 at T+4.
//  4 sw addr=(4*1023+2), wdata=0x44332211 (ADDR_W=10) -> ACC0 addr=1023 be=1100 wdata=0x22114433,
//    ACC1 addr=0 be=0011; resp T+4.
//  5 load funct3=011 -> no mem_en, resp_valid+resp_err=1 at T+1; back-to-back req accepted T+2.
//  6 rst_n low during ACC1 of split load -> outputs 0, req_ready=1, no resp_valid after release.

Source files
------------

// File: rtl/lsu_ctrl.sv
// ============================================================================
//  Module   : lsu_ctrl
//  Purpose  : RV32I load/store initiator issuing byte-enabled word accesses,
//             splitting word-crossing accesses and extending load results.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC0 = 3'd1,
        S_ACC1 = 3'd2,
        S_WAIT = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic [1:0]          off_q, off_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be1_q, be1_d;
    logic [31:0]         lo_q, lo_d;

    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;

    logic [3:0]          w_mask;
    logic [7:0]          w_be8;
    logic [31:0]         w_rot;
    logic                w_illegal;
    logic                w_split;
    logic [31:0]         w_hi, w_lo, w_x, w_ext;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    // Request-side decode: lane mask spans two words when w_be8[7:4] is non-zero.
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   w_mask = 4'b0001;
            2'b01:   w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
    end

    assign w_be8     = {4'b0000, w_mask} << req_addr[1:0];
    assign w_rot     = 32'({req_wdata, req_wdata} >> (6'd32 - {1'b0, req_addr[1:0], 3'b000}));
    assign w_illegal = req_we ? (req_funct3 > 3'b010)
                              : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));

    // Unsplit loads see their only word in WAIT; split loads see the high word there.
    assign w_split = (be1_q != 4'b0000);
    assign w_hi    = w_split ? mem_rdata : 32'd0;
    assign w_lo    = w_split ? lo_q : mem_rdata;
    assign w_x     = 32'({w_hi, w_lo} >> {off_q, 3'b000});

    always_comb begin
        case (f3_q)
            3'b000:  w_ext = {{24{w_x[7]}}, w_x[7:0]};
            3'b001:  w_ext = {{16{w_x[15]}}, w_x[15:0]};
            3'b100:  w_ext = {24'd0, w_x[7:0]};
            3'b101:  w_ext = {16'd0, w_x[15:0]};
            default: w_ext = w_x;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        off_d        = off_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        be1_d        = be1_q;
        lo_d         = lo_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_be_d     = 4'b0000;
        mem_addr_d   = '0;
        mem_wdata_d  = 32'd0;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    off_d   = req_addr[1:0];
                    waddr_d = req_addr[ADDR_W+1:2];
                    wdata_d = w_rot;
                    be1_d   = w_be8[7:4];
                    if (w_illegal) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else begin
                        state_d     = S_ACC0;
                        mem_en_d    = 1'b1;
                        mem_we_d    = req_we;
                        mem_be_d    = w_be8[3:0];
                        mem_addr_d  = req_addr[ADDR_W+1:2];
                        mem_wdata_d = w_rot;
                    end
                end
            end
            S_ACC0: begin
                if (w_split) begin
                    state_d     = S_ACC1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_q;
                    mem_be_d    = be1_q;
                    mem_addr_d  = waddr_q + ADDR_W'(1);
                    mem_wdata_d = wdata_q;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ACC1: begin
                lo_d    = mem_rdata;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = we_q ? 32'd0 : w_ext;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            waddr_q      <= '0;
            wdata_q      <= 32'd0;
            be1_q        <= 4'b0000;
            lo_q         <= 32'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'b0000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            be1_q        <= be1_d;
            lo_q         <= lo_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

`default_nettype wire
